// File: rtl/system_acl_iface_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : system_acl_iface_key_pkg
// Description : Constants shared by the system_acl_iface PIO slaves: the
//               Avalon-MM register offsets and the debounce counter sizing
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package system_acl_iface_key_pkg;

  // Register word offsets common to every PIO slave on the interface
  localparam logic [1:0] c_addr_data = 2'd0;
  localparam logic [1:0] c_addr_mask = 2'd1;
  localparam logic [1:0] c_addr_edge = 2'd2;
  localparam logic [1:0] c_addr_rsvd = 2'd3;

  // Bits needed for a counter that must be able to hold the value `cycles`
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/system_acl_iface_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : system_acl_iface_key_debounce
// Description : One key bit: two-flop synchronizer followed by a run-length
//               debounce counter. o_accept pulses in the cycle the debounced
//               level is about to flip, so the parent can capture edges on
//               the same clock edge the level changes.
// Revision    : 1.0 - initial release
// ============================================================================
module system_acl_iface_key_debounce
  import system_acl_iface_key_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_accept
);

  localparam int               CNT_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;
  logic             w_accept;

  // The count already holds DEBOUNCE_CYCLES-1 mismatching cycles, so this
  // cycle is the one that would make it reach DEBOUNCE_CYCLES.
  assign w_differ = r_sync ^ r_level;
  assign w_accept = w_differ && (r_cnt == c_cnt_last);

  // Two-flop synchronizer for the asynchronous key input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_LEVEL;
      r_sync <= RESET_LEVEL;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Count consecutive mismatching cycles; any match or an accept restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!w_differ || w_accept) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Debounced level follows the synchronized input once the run completes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= RESET_LEVEL;
    end else if (w_accept) begin
      r_level <= r_sync;
    end
  end

  assign o_level  = r_level;
  assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/system_acl_iface_key.sv
`default_nettype none
// ============================================================================
// Module      : system_acl_iface_key
// Description : Debounced key PIO slave on Avalon-MM. Registers: debounced
//               data (RO), interrupt mask (RW), edge capture (W1C), one
//               reserved word. Level interrupt from masked edge capture.
// Revision    : 1.0 - initial release
// ============================================================================
module system_acl_iface_key
  import system_acl_iface_key_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1,
  parameter logic             CAPTURE_RISING  = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clear;
  logic             w_write;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      system_acl_iface_key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_LEVEL     (RESET_LEVEL[g])
      ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_raw    (in_port[g]),
        .o_level  (w_level[g]),
        .o_accept (w_accept[g])
      );
    end
  endgenerate

  // Upper writedata bits carry no register state
  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic w_unused;
      assign w_unused = &{1'b0, writedata[31:WIDTH]};
    end
  endgenerate

  assign w_write = chipselect && !write_n;

  // An accept flips the level, so the current level tells the direction:
  // high now means a falling edge is being accepted.
  assign w_set   = w_accept & (CAPTURE_RISING ? ~w_level : w_level);
  assign w_clear = (w_write && address == c_addr_edge) ? writedata[WIDTH-1:0] : '0;

  // Interrupt mask register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
    end else if (w_write && address == c_addr_mask) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  // Edge capture: set dominates a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clear) | w_set;
    end
  end

  // Zero-latency read mux, zero-extended; reads have no side effects
  always_comb begin
    readdata = '0;
    case (address)
      c_addr_data: readdata[WIDTH-1:0] = w_level;
      c_addr_mask: readdata[WIDTH-1:0] = r_mask;
      c_addr_edge: readdata[WIDTH-1:0] = r_edge;
      default:     readdata            = '0;
    endcase
  end

  assign irq = |(r_edge & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_system_acl_iface_key.sv
`default_nettype none
// ============================================================================
// Module      : tb_system_acl_iface_key
// Description : Self-checking bench for system_acl_iface_key (WIDTH=4,
//               DEBOUNCE_CYCLES=4, falling-edge capture) with a behavioural
//               reference model and directed plus random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_system_acl_iface_key;

  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] in_port;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  system_acl_iface_key #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N),
    .RESET_LEVEL     (4'hF),
    .CAPTURE_RISING  (1'b0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The debounced bit flips when the last N synchronized samples all
  // disagree with it; the synchronized value is in_port two edges late.
  logic [W-1:0] m_s1, m_s2, m_deb, m_mask, m_edge;
  logic [N-1:0] m_hist [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_deb = '1; m_mask = '0; m_edge = '0;
      for (int b = 0; b < W; b++) m_hist[b] = '1;
    end else begin
      logic [W-1:0] set_v, clr_v;
      set_v = '0;
      clr_v = '0;
      for (int b = 0; b < W; b++) begin
        m_hist[b] = {m_hist[b][N-2:0], m_s2[b]};
        if (m_hist[b] == {N{~m_deb[b]}}) begin
          if (m_deb[b]) set_v[b] = 1'b1;
          m_deb[b] = ~m_deb[b];
        end
      end
      if (chipselect && !write_n) begin
        if (address == 2'd1) m_mask = writedata[W-1:0];
        if (address == 2'd2) clr_v = writedata[W-1:0];
      end
      m_edge = (m_edge & ~clr_v) | set_v;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_deb};
      2'd1:    return {28'd0, m_mask};
      2'd2:    return {28'd0, m_edge};
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: DUT outputs against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_readdata", readdata, model_read(address));
      check("model_irq", {31'd0, irq}, {31'd0, |(m_edge & m_mask)});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  initial begin
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    tick(3);

    // Reset state
    rd(2'd0, "reset_data", 32'hF);
    rd(2'd1, "reset_mask", 32'h0);
    rd(2'd2, "reset_edge", 32'h0);
    rd(2'd3, "reset_rsvd", 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(2);
    chk_en = 1'b1;

    // Press bit 0: data changes exactly 6 cycles later
    address = 2'd0;
    in_port = 4'hE;
    tick(5);
    rd(2'd0, "press_before", 32'hF);
    tick();
    rd(2'd0, "press_data", 32'hE);
    rd(2'd2, "press_edge", 32'h1);
    check("press_irq_masked", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    // Release: no rising capture
    in_port = 4'hF;
    tick(8);
    rd(2'd0, "release_data", 32'hF);
    rd(2'd2, "release_edge", 32'h0);

    // IRQ path
    wr(2'd1, 32'h1);
    in_port = 4'hE;
    tick(6);
    check("irq_rise", {31'd0, irq}, 32'h1);
    rd(2'd2, "irq_edge", 32'h1);
    address = 2'd2; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    #1;
    check("irq_hold_before_clear", {31'd0, irq}, 32'h1);
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    check("irq_fall", {31'd0, irq}, 32'h0);
    rd(2'd2, "irq_edge_cleared", 32'h0);
    in_port = 4'hF;
    tick(8);

    // Glitch of 3 cycles rejected, 4-cycle hold accepted
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(8);
    rd(2'd0, "glitch_data", 32'hF);
    rd(2'd2, "glitch_edge", 32'h0);
    in_port = 4'hD;
    tick(4);
    in_port = 4'hF;
    tick(2);
    rd(2'd0, "hold4_data", 32'hD);
    rd(2'd2, "hold4_edge", 32'h2);
    tick(8);
    wr(2'd2, 32'hF);

    // Collision: falling edge on bit 2 with simultaneous clear of bit 2
    in_port = 4'hB;
    tick(5);
    wr(2'd2, 32'h4);
    rd(2'd0, "collide_data", 32'hB);
    rd(2'd2, "collide_edge", 32'h4);
    in_port = 4'hF;
    tick(8);

    // Reserved write changes nothing
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd0, "rsvd_data", 32'hF);
    rd(2'd1, "rsvd_mask", 32'h1);
    rd(2'd2, "rsvd_edge", 32'h4);
    rd(2'd3, "rsvd_read", 32'h0);

    // Randomized traffic, occasional reset mid-debounce
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0)
        in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      address = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) == 0);
      write_n = ($urandom_range(0, 1) == 0);
      writedata = $urandom;
      if ($urandom_range(0, 400) == 0) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
    tick(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
